// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters.
// Grants one requester at a time for a burst of up to BURST words.
module fifo_write_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned BURST = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              EN,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*DW-1:0] reqData,
  input  logic [N_REQ-1:0]  last,
  output logic [N_REQ-1:0]  ack,
  output logic [N_REQ-1:0]  grant,
  input  logic              fifoFull,
  output logic              fifoWR,
  output logic [DW-1:0]     fifoData,
  output logic              busy
);

  localparam int unsigned PW = $clog2(N_REQ);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PW-1:0]    pick;
  logic             found;
  logic             accept;
  logic             release_grant;
  int unsigned      idx;

  // Rotating priority search starting just after the last granted index.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  // While in StXfer, ptr_q holds the granted index.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    accept        = 1'b0;
    release_grant = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (EN && found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          ptr_d         = pick;
          cnt_d         = '0;
          state_d       = StXfer;
        end
      end
      StXfer: begin
        accept = EN & req[ptr_q] & ~fifoFull;
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (last[ptr_q] || (cnt_q + 4'd1 == 4'(BURST))) release_grant = 1'b1;
        end
        if (EN && !req[ptr_q]) release_grant = 1'b1;
        if (release_grant) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= PW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fifoData = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) fifoData = fifoData | reqData[i*DW +: DW];
    end
  end

  assign ack    = accept ? grant_q : '0;
  assign fifoWR = accept;
  assign grant  = grant_q;
  assign busy   = (state_q == StXfer);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: vector table, directed corner sequences and a
// randomized run, all checked against a cycle-level ownership model.
module tb_fifo_write_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 16;
  localparam int BURST = 4;

  logic              Clk;
  logic              Rst;
  logic              EN;
  logic [N_REQ-1:0]  req;
  logic [N_REQ*DW-1:0] reqData;
  logic [N_REQ-1:0]  last;
  logic [N_REQ-1:0]  ack;
  logic [N_REQ-1:0]  grant;
  logic              fifoFull;
  logic              fifoWR;
  logic [DW-1:0]     fifoData;
  logic              busy;

  fifo_write_arbiter #(
    .N_REQ (N_REQ),
    .DW    (DW),
    .BURST (BURST)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .EN       (EN),
    .req      (req),
    .reqData  (reqData),
    .last     (last),
    .ack      (ack),
    .grant    (grant),
    .fifoFull (fifoFull),
    .fifoWR   (fifoWR),
    .fifoData (fifoData),
    .busy     (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: who owns the port (-1 = nobody), last winner, words in this grant.
  int  m_owner = -1;
  int  m_ptr   = N_REQ - 1;
  int  m_cnt   = 0;
  bit  model_valid = 0;

  logic [3:0]  obs_grant, obs_ack;
  logic        obs_wr, obs_busy;
  logic [15:0] obs_data;
  logic [15:0] wq[$];

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lst;
    logic [15:0] word;
    logic [3:0]  e_grant;
    logic [3:0]  e_ack;
    logic        e_wr;
    logic        e_busy;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [3:0] r,
                      input logic [3:0] l, input logic full, input logic [63:0] d);
    logic [3:0]  e_grant, e_ack;
    logic        e_acc;
    logic [15:0] e_data;
    Rst = rst; EN = en; req = r; last = l; fifoFull = full; reqData = d;
    #1;
    obs_grant = grant; obs_ack = ack; obs_wr = fifoWR; obs_busy = busy; obs_data = fifoData;
    if (fifoWR) wq.push_back(fifoData);
    e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e_acc   = (m_owner >= 0) && en && r[m_owner] && !full;
    e_ack   = e_acc ? e_grant : 4'b0000;
    e_data  = (m_owner >= 0) ? d[m_owner*16 +: 16] : 16'h0000;
    if (model_valid)
      check("model", {obs_grant, obs_ack, obs_wr, obs_busy, obs_data},
            {e_grant, e_ack, e_acc, (m_owner >= 0), e_data});
    @(posedge Clk);
    if (rst) begin
      m_owner = -1; m_ptr = N_REQ - 1; m_cnt = 0; model_valid = 1;
    end else if (en) begin
      if (m_owner < 0) begin
        for (int k = 1; k <= N_REQ; k++) begin
          if (m_owner < 0 && r[(m_ptr + k) % N_REQ]) begin
            m_owner = (m_ptr + k) % N_REQ; m_ptr = m_owner; m_cnt = 0;
          end
        end
      end else begin
        if (e_acc) m_cnt++;
        if ((e_acc && (l[m_owner] || m_cnt == BURST)) || !r[m_owner]) m_owner = -1;
      end
    end
    @(negedge Clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int wrs;
    Rst = 1'b1; EN = 1'b0; req = '0; last = '0; fifoFull = 1'b0; reqData = '0;
    @(negedge Clk);
    step(1, 1, 4'b0000, 4'b0000, 0, 64'd0);
    step(1, 1, 4'b0000, 4'b0000, 0, 64'd0);

    // Single requester, 6-word packet with last on word 6.
    tbl[0]  = '{4'b0000, 4'b0000, 16'd0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{4'b0001, 4'b0000, 16'd1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[2]  = '{4'b0001, 4'b0000, 16'd1, 4'b0001, 4'b0001, 1'b1, 1'b1};
    tbl[3]  = '{4'b0001, 4'b0000, 16'd2, 4'b0001, 4'b0001, 1'b1, 1'b1};
    tbl[4]  = '{4'b0001, 4'b0000, 16'd3, 4'b0001, 4'b0001, 1'b1, 1'b1};
    tbl[5]  = '{4'b0001, 4'b0000, 16'd4, 4'b0001, 4'b0001, 1'b1, 1'b1};
    tbl[6]  = '{4'b0001, 4'b0000, 16'd5, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[7]  = '{4'b0001, 4'b0000, 16'd5, 4'b0001, 4'b0001, 1'b1, 1'b1};
    tbl[8]  = '{4'b0001, 4'b0001, 16'd6, 4'b0001, 4'b0001, 1'b1, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0000, 16'd0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 16'd0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    wq.delete();
    for (int i = 0; i < 11; i++) begin
      step(0, 1, tbl[i].req, tbl[i].lst, 0, {16'hD333, 16'hD222, 16'hD111, tbl[i].word});
      check($sformatf("table[%0d]", i), {obs_grant, obs_ack, obs_wr, obs_busy},
            {tbl[i].e_grant, tbl[i].e_ack, tbl[i].e_wr, tbl[i].e_busy});
    end
    check("table_wcount", 64'(wq.size()), 64'd6);
    for (int i = 0; i < 6 && i < wq.size(); i++)
      check($sformatf("table_word[%0d]", i), 64'(wq[i]), 64'(i + 1));

    // Round-robin fairness from reset.
    step(1, 1, 4'b1111, 4'b0000, 0, rnd64());
    for (int c = 0; c < 25; c++) begin
      step(0, 1, 4'b1111, 4'b0000, 0, rnd64());
      check($sformatf("rr[%0d]", c), {obs_grant, obs_wr},
            {((c % 5 == 0) ? 4'b0000 : 4'(1 << ((c / 5) % 4))), (c % 5 != 0)});
    end

    // Back-pressure after word 2.
    step(1, 1, 4'b0000, 4'b0000, 0, 64'd0);
    for (int c = 0; c < 9; c++) begin
      step(0, 1, 4'b0001, 4'b0000, (c >= 3 && c <= 5), rnd64());
      check($sformatf("bp[%0d]", c), {obs_grant, obs_wr},
            {((c >= 1 && c <= 7) ? 4'b0001 : 4'b0000), (c == 1 || c == 2 || c == 6 || c == 7)});
    end

    // Early release by requester 2, then requester 3 wins.
    step(1, 1, 4'b0000, 4'b0000, 0, 64'd0);
    step(0, 1, 4'b0100, 4'b0000, 0, rnd64());
    step(0, 1, 4'b0100, 4'b0000, 0, rnd64());
    check("early_w1", {obs_grant, obs_wr}, {4'b0100, 1'b1});
    step(0, 1, 4'b0000, 4'b0000, 0, rnd64());
    check("early_drop", {obs_grant, obs_wr}, {4'b0100, 1'b0});
    step(0, 1, 4'b1100, 4'b0000, 0, rnd64());
    check("early_idle", {obs_grant, obs_busy}, {4'b0000, 1'b0});
    step(0, 1, 4'b1100, 4'b0000, 0, rnd64());
    check("early_next", obs_grant, 4'b1000);

    // EN freeze mid-burst.
    step(1, 1, 4'b0000, 4'b0000, 0, 64'd0);
    wrs = 0;
    for (int c = 0; c < 11; c++) begin
      step(0, !(c >= 3 && c <= 7), 4'b0001, 4'b0000, 0, rnd64());
      if (obs_wr) wrs++;
      if (c >= 3 && c <= 7) check($sformatf("freeze[%0d]", c), {obs_grant, obs_ack, obs_wr},
                                  {4'b0001, 4'b0000, 1'b0});
    end
    check("freeze_words", 64'(wrs), 64'd4);

    // Reset mid-burst to requester 1.
    step(1, 1, 4'b0000, 4'b0000, 0, 64'd0);
    step(0, 1, 4'b0010, 4'b0000, 0, rnd64());
    step(0, 1, 4'b0010, 4'b0000, 0, rnd64());
    step(0, 1, 4'b0010, 4'b0000, 0, rnd64());
    step(1, 1, 4'b0011, 4'b0000, 0, rnd64());
    step(0, 1, 4'b0011, 4'b0000, 0, rnd64());
    check("rst_mid", {obs_grant, obs_wr, obs_busy}, {4'b0000, 1'b0, 1'b0});
    step(0, 1, 4'b0011, 4'b0000, 0, rnd64());
    check("rst_winner", obs_grant, 4'b0001);

    // Randomized run against the model.
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) != 0), 4'($urandom),
           4'($urandom) & 4'($urandom), ($urandom_range(3) == 0), rnd64());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of a 16-bit PE input FIFO among several requesters (e.g. ifmap, filter and psum feeders from the GLB/NoC side). It grants one requester at a time for a bounded burst. It steers the granted requester's data onto the FIFO's write port and back-pressures on FIFO FULL. Downstream it drives the FIFO's WR/dataIn pins directly; the FIFO's RD side is untouched.

## Interface

**Parameters**
- N_REQ, 4: number of requesters, 2..8.
- DW, 16: data width.
- BURST, 4: max words per grant, 1..15.

**Ports**
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- EN  in  1  global enable; 0 freezes all state.
- req  in  N_REQ  requester i has a word available on its data slice.
- reqData  in  N_REQ*DW  requester i data at bits [i*DW +: DW].
- last  in  N_REQ  current word of requester i is the final word of its packet.
- ack  out  N_REQ  one-hot; word of granted requester accepted this cycle (combinational).
- grant  out  N_REQ  one-hot registered grant; 0 when idle.
- fifoFull  in  1  FULL from the target FIFO.
- fifoWR  out  1  write strobe to FIFO (combinational).
- fifoData  out  DW  data to FIFO = reqData slice of the granted requester, 0 when no grant.
- busy  out  1  state == XFER.

## Operation

- FSM states: IDLE, XFER.
- Registers: grant (one-hot), ptr (index of the last granted requester, clog2(N_REQ) bits), cnt (words in current grant, 4 bits).
- IDLE:
  - If any req bit is set, select the first set bit searching ptr+1, ptr+2, … modulo N_REQ.
  - Load grant with that one-hot value, load ptr with its index, clear cnt, go to XFER.
  - Otherwise stay in IDLE with grant = 0.
- XFER, with g the granted index:
  - accept = EN & req[g] & ~fifoFull.
  - ack[g] = fifoWR = accept; fifoData = reqData[g].
  - On accept, cnt increments.
- Grant release from XFER to IDLE (grant cleared, ptr kept) occurs at the first of these:
  - an accepted word with last[g] = 1;
  - an accepted word that brings cnt to BURST;
  - req[g] = 0 while EN = 1, i.e. the requester withdrew.
- fifoFull stall: holds the grant. No release and no count change; the grant is held indefinitely while req[g] stays high.
- EN = 0:
  - No state, ptr or cnt change.
  - ack = 0, fifoWR = 0.
  - grant is held.
- Rst:
  - Takes priority over EN.
  - State = IDLE, grant = 0, cnt = 0, ptr = N_REQ-1, so requester 0 has first priority.
  - Reset mid-burst aborts the burst with no further ack or fifoWR.
- ack and fifoWR are never asserted in IDLE, never for a non-granted requester, and never while fifoFull = 1.

## Timing

- Reset values:
  - grant = 0, busy = 0, ack = 0, fifoWR = 0, fifoData = 0.
  - ptr = N_REQ-1, cnt = 0.
- Grant latency: req rising in IDLE gives grant/busy high on the next cycle; the first ack is possible in that same cycle.
- Transfer: one word per cycle while accept holds. The word is written into the FIFO and consumed by the requester on the same Clk edge. The requester presents its next word after that edge.
- Inter-grant gap: exactly one IDLE cycle after every release. Sustained throughput with all requesters active is BURST/(BURST+1) words per cycle.
- fifoFull is sampled combinationally each cycle. The FIFO's FULL reflects its post-edge count, so no write is ever issued into a full FIFO.
- Simultaneous events:
  - The last word and the BURST limit on the same accept produce a single release.
  - A withdrawn req with fifoFull = 1 still releases.

## Test plan

- Reset then single requester: req = 0001, 6 words, last on word 6, BURST = 4. Expect grant 0001 for 4 acks, one IDLE cycle, re-grant 0001 for 2 acks, then IDLE; the FIFO receives 6 words in order.
- Round-robin fairness: req = 1111 held, no last. Expect the grant order 0001, 0010, 0100, 1000, 0001, each with 4 consecutive fifoWR pulses separated by 1 idle cycle.
- Back-pressure: fifoFull = 1 for 3 cycles mid-burst after word 2. Expect ack = fifoWR = 0 during those cycles, grant unchanged, then words 3-4 written and release after word 4.
- Early release: requester 2 gets the grant, sends 1 word, then drops req. Expect release on the cycle req drops, ptr = 2, and requester 3 granted next when req = 1100.
- EN freeze: EN = 0 for 5 cycles mid-burst with req high. Expect no ack or fifoWR and grant/cnt held; resuming EN = 1 completes the remaining burst words exactly.
- Reset mid-burst: Rst pulses after 2 acks to requester 1. Next cycle expect grant = 0, fifoWR = 0, and ptr = N_REQ-1, so requester 0 wins the next arbitration against req = 0011.
